// File: rtl/umai_tx_flit_packer_pkg.sv
// Shared widths, tag encodings and FSM state type for the UMAI TX flit packer.
package umai_flit_pkg;

    localparam int FlitW        = 72;
    localparam int BeatW        = 512;
    localparam int FlitsPerBeat = 8;
    localparam int SliceW       = BeatW / FlitsPerBeat;
    localparam int IdxW         = $clog2(FlitsPerBeat);

    localparam logic [1:0]      DataTagPrefix = 2'b10;
    localparam logic [IdxW-1:0] LastIdx       = IdxW'(FlitsPerBeat - 1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        WAIT_BEAT,
        SEND_BEAT
    } state_e;

    function automatic logic [7:0] data_tag(input logic last, input logic [IdxW-1:0] idx);
        return {DataTagPrefix, last, 2'b00, idx};
    endfunction

endpackage

// File: rtl/umai_tx_flit_packer_if.sv
// Command, write-data and AIB flit channels of the TX flit packer.
interface umai_tx_flit_packer_if;
    import umai_flit_pkg::*;

    logic             i_cmd_valid;
    logic             o_cmd_ready;
    logic             i_cmd_write;
    logic [31:0]      i_cmd_addr;
    logic [5:0]       i_cmd_len;

    logic             i_data_valid;
    logic             o_data_ready;
    logic [BeatW-1:0] i_data;

    logic             o_tx_valid;
    logic             i_tx_ready;
    logic [FlitW-1:0] o_tx_data;

    modport slave (
        input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
        input  i_data_valid, i_data, i_tx_ready,
        output o_cmd_ready, o_data_ready, o_tx_valid, o_tx_data
    );

    modport master (
        output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
        output i_data_valid, i_data, i_tx_ready,
        input  o_cmd_ready, o_data_ready, o_tx_valid, o_tx_data
    );

endinterface

// File: rtl/umai_tx_flit_packer_beat_shifter.sv
// Holds one 512-bit write beat and presents the 64-bit slice chosen by the flit index.
module umai_beat_shifter
    import umai_flit_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              load,
    input  logic [BeatW-1:0]  load_data,
    input  logic [IdxW-1:0]   sel,
    output logic [SliceW-1:0] slice
);

    logic [BeatW-1:0] beat_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            beat_q <= '0;
        end else if (load) begin
            beat_q <= load_data;
        end
    end

    assign slice = beat_q[sel * SliceW +: SliceW];

endmodule

// File: rtl/umai_tx_flit_packer.sv
// Packs read/write commands and 512-bit write beats into 72-bit AIB flits.
//
// state     | meaning
// IDLE      | ready for a command, no flit on the channel
// HDR       | header flit held on the channel until accepted
// WAIT_BEAT | write burst waiting for the next data beat
// SEND_BEAT | streaming the eight 64-bit slices of the current beat
module umai_tx_flit_packer
    import umai_flit_pkg::*;
#(
    parameter logic [7:0] WrHdrTag = 8'hA5,
    parameter logic [7:0] RdHdrTag = 8'h5A
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    umai_tx_flit_packer_if.slave bus
);

    state_e            state;
    logic [5:0]        len_q;
    logic              write_q;
    logic [5:0]        beat_cnt;
    logic [IdxW-1:0]   flit_idx;
    logic              cmd_ready;
    logic              data_ready;
    logic              tx_valid;
    logic [FlitW-1:0]  tx_data;

    logic              cmd_fire;
    logic              data_fire;
    logic              tx_fire;
    logic              last_beat;
    logic [IdxW-1:0]   next_idx;
    logic [SliceW-1:0] next_slice;

    assign cmd_fire  = bus.i_cmd_valid & cmd_ready;
    assign data_fire = bus.i_data_valid & data_ready;
    assign tx_fire   = tx_valid & bus.i_tx_ready;
    assign last_beat = (beat_cnt == len_q);
    assign next_idx  = flit_idx + 1'b1;

    // Slice for the flit after the current one, so tx_data can stay registered.
    umai_beat_shifter u_beat_shifter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .load      (data_fire),
        .load_data (bus.i_data),
        .sel       (next_idx),
        .slice     (next_slice)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            len_q      <= '0;
            write_q    <= 1'b0;
            beat_cnt   <= '0;
            flit_idx   <= '0;
            cmd_ready  <= 1'b0;
            data_ready <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        len_q     <= bus.i_cmd_len;
                        write_q   <= bus.i_cmd_write;
                        cmd_ready <= 1'b0;
                        tx_valid  <= 1'b1;
                        tx_data   <= {(bus.i_cmd_write ? WrHdrTag : RdHdrTag),
                                      26'b0, bus.i_cmd_len, bus.i_cmd_addr};
                        state     <= HDR;
                    end
                end
                HDR: begin
                    if (tx_fire) begin
                        tx_valid <= 1'b0;
                        if (write_q) begin
                            beat_cnt   <= '0;
                            data_ready <= 1'b1;
                            state      <= WAIT_BEAT;
                        end else begin
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                WAIT_BEAT: begin
                    if (data_fire) begin
                        data_ready <= 1'b0;
                        flit_idx   <= '0;
                        tx_valid   <= 1'b1;
                        // First slice comes straight off the bus while the beat register loads.
                        tx_data    <= {data_tag(1'b0, '0), bus.i_data[SliceW-1:0]};
                        state      <= SEND_BEAT;
                    end
                end
                SEND_BEAT: begin
                    if (tx_fire) begin
                        if (flit_idx == LastIdx) begin
                            tx_valid <= 1'b0;
                            if (last_beat) begin
                                cmd_ready <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                beat_cnt   <= beat_cnt + 6'd1;
                                data_ready <= 1'b1;
                                state      <= WAIT_BEAT;
                            end
                        end else begin
                            flit_idx <= next_idx;
                            tx_data  <= {data_tag(last_beat && (next_idx == LastIdx), next_idx),
                                         next_slice};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_cmd_ready  = cmd_ready;
    assign bus.o_data_ready = data_ready;
    assign bus.o_tx_valid   = tx_valid;
    assign bus.o_tx_data    = tx_data;

endmodule

// File: tb/tb_umai_tx_flit_packer.sv
// Directed bench for the TX flit packer with a flit-queue reference model checked every cycle.
module tb_umai_tx_flit_packer;
    import umai_flit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    umai_tx_flit_packer_if bus ();

    umai_tx_flit_packer #(
        .WrHdrTag (8'hA5),
        .RdHdrTag (8'h5A)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int tx_mode = 0;

    logic [71:0] exp_q[$];
    logic [71:0] seen[$];
    bit          busy = 1'b0;
    bit          fresh = 1'b1;
    bit          prev_stall = 1'b0;
    logic [71:0] prev_data = '0;
    int          beats_rem = 0;
    int          beat_no = 0;
    int          m_len = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] hdr_flit(input bit w, input logic [31:0] a, input logic [5:0] l);
        return {(w ? 8'hA5 : 8'h5A), 26'b0, l, a};
    endfunction

    function automatic logic [71:0] data_flit(input int b, input int k, input int len, input logic [511:0] d);
        logic [7:0] tag;
        tag = 8'h80 | 8'(k) | (((b == len) && (k == 7)) ? 8'h20 : 8'h00);
        return {tag, d[64*k +: 64]};
    endfunction

    function automatic logic [511:0] rand_beat();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // Reference model: every accepted command/beat appends the flits it must produce.
    always @(negedge clk) begin
        logic [71:0] e;
        if (rst) begin
            check("rst_tx_valid",   72'(bus.o_tx_valid), 72'(0));
            check("rst_tx_data",    bus.o_tx_data, 72'(0));
            check("rst_cmd_ready",  72'(bus.o_cmd_ready), 72'(0));
            check("rst_data_ready", 72'(bus.o_data_ready), 72'(0));
            exp_q.delete();
            busy = 1'b0;
            fresh = 1'b1;
            prev_stall = 1'b0;
            beats_rem = 0;
        end else begin
            check("tx_valid",   72'(bus.o_tx_valid), 72'(exp_q.size() != 0));
            check("cmd_ready",  72'(bus.o_cmd_ready), 72'(!busy && !fresh));
            check("data_ready", 72'(bus.o_data_ready), 72'(busy && exp_q.size() == 0 && beats_rem > 0));
            if (prev_stall) check("tx_hold_data", bus.o_tx_data, prev_data);
            prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
            prev_data  = bus.o_tx_data;

            if (bus.o_tx_valid && bus.i_tx_ready) begin
                seen.push_back(bus.o_tx_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got flit %h expected none", bus.o_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", bus.o_tx_data, e);
                    if (exp_q.size() == 0 && beats_rem == 0) busy = 1'b0;
                end
            end
            if (bus.i_data_valid && bus.o_data_ready) begin
                for (int k = 0; k < 8; k++) exp_q.push_back(data_flit(beat_no, k, m_len, bus.i_data));
                beat_no++;
                beats_rem--;
            end
            if (bus.i_cmd_valid && bus.o_cmd_ready) begin
                exp_q.push_back(hdr_flit(bus.i_cmd_write, bus.i_cmd_addr, bus.i_cmd_len));
                busy = 1'b1;
                m_len = int'(bus.i_cmd_len);
                beat_no = 0;
                beats_rem = bus.i_cmd_write ? m_len + 1 : 0;
            end
            fresh = 1'b0;
        end
    end

    initial begin
        bus.i_tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.i_tx_ready = (tx_mode == 0) ? 1'b1 : 1'(($urandom % 3) != 0);
        end
    end

    task automatic wait_accept();
        int n = 0;
        bit ok = 1'b0;
        while (!ok && n < 3000) begin
            @(negedge clk);
            n++;
            if (bus.o_cmd_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.i_cmd_valid = 1'b0;
        check("cmd_accept_timeout", 72'(ok), 72'(1));
    endtask

    task automatic send_cmd(input bit w, input logic [31:0] a, input logic [5:0] l);
        @(posedge clk);
        #1;
        bus.i_cmd_write = w;
        bus.i_cmd_addr  = a;
        bus.i_cmd_len   = l;
        bus.i_cmd_valid = 1'b1;
        wait_accept();
    endtask

    task automatic send_beat(input logic [511:0] d);
        int n = 0;
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        bus.i_data = d;
        bus.i_data_valid = 1'b1;
        while (!ok && n < 3000) begin
            @(negedge clk);
            n++;
            if (bus.o_data_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.i_data_valid = 1'b0;
        check("beat_accept_timeout", 72'(ok), 72'(1));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!bus.o_cmd_ready && n < 3000);
        check(name, 72'(bus.o_cmd_ready), 72'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [511:0] d;
        logic [511:0] bd;

        bus.i_cmd_valid  = 1'b0;
        bus.i_cmd_write  = 1'b0;
        bus.i_cmd_addr   = '0;
        bus.i_cmd_len    = '0;
        bus.i_data_valid = 1'b0;
        bus.i_data       = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_tx_valid",  72'(bus.o_tx_valid), 72'(0));
        check("reset_cmd_ready", 72'(bus.o_cmd_ready), 72'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("cmd_ready_first_edge", 72'(bus.o_cmd_ready), 72'(1));

        // Data offered with no command must be ignored
        bus.i_data = rand_beat();
        bus.i_data_valid = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("data_ready_no_cmd", 72'(bus.o_data_ready), 72'(0));
        check("no_flits_no_cmd", 72'(seen.size()), 72'(0));
        @(posedge clk);
        #1;
        bus.i_data_valid = 1'b0;

        // Read command: single header flit
        base = seen.size();
        send_cmd(1'b0, 32'h1234_5678, 6'd3);
        wait_idle("rd_idle");
        check("rd_count", 72'(seen.size() - base), 72'(1));
        check("rd_hdr", seen[base], 72'h5A_0000_0003_1234_5678);

        // Write len=0, slices 0..7, with a read held off during the burst
        base = seen.size();
        send_cmd(1'b1, 32'h0000_1000, 6'd0);
        bus.i_cmd_write = 1'b0;
        bus.i_cmd_addr  = 32'hCAFE_0000;
        bus.i_cmd_len   = 6'd5;
        bus.i_cmd_valid = 1'b1;
        for (int k = 0; k < 8; k++) d[64*k +: 64] = 64'(k);
        send_beat(d);
        @(negedge clk);
        #1;
        check("cmd_held_off", 72'(bus.o_cmd_ready), 72'(0));
        wait_accept();
        wait_idle("wr0_idle");
        check("wr0_count", 72'(seen.size() - base), 72'(10));
        check("wr0_hdr", seen[base], 72'hA5_0000_0000_0000_1000);
        for (int k = 0; k < 8; k++) begin
            check("wr0_tag", 72'(seen[base+1+k][71:64]), 72'((k == 7) ? 8'hA7 : 8'h80 + 8'(k)));
            check("wr0_payload", 72'(seen[base+1+k][63:0]), 72'(k));
        end
        check("held_rd_hdr", seen[base+9], 72'h5A_0000_0005_CAFE_0000);

        // Write len=1 under random backpressure
        base = seen.size();
        tx_mode = 1;
        send_cmd(1'b1, 32'hDEAD_BEEF, 6'd1);
        send_beat(rand_beat());
        send_beat(rand_beat());
        wait_idle("wr1_idle");
        tx_mode = 0;
        check("wr1_count", 72'(seen.size() - base), 72'(17));
        check("wr1_hdr", seen[base], 72'hA5_0000_0001_DEAD_BEEF);
        for (int i = 1; i <= 16; i++) check("wr1_last_bit", 72'(seen[base+i][69]), 72'(i == 16));

        // Write len=63: 64 beats without counter wrap
        base = seen.size();
        send_cmd(1'b1, 32'h8000_0000, 6'd63);
        for (int b = 0; b < 64; b++) send_beat(rand_beat());
        wait_idle("wr63_idle");
        check("wr63_count", 72'(seen.size() - base), 72'(513));
        check("wr63_beat_cnt", 72'(dut.beat_cnt), 72'(63));
        check("wr63_last_tag", 72'(seen[base+512][71:64]), 72'(8'hA7));
        check("wr63_penult_tag", 72'(seen[base+504][71:64]), 72'(8'h87));

        // Reset pulsed while flit 3 of beat 0 is on the channel
        base = seen.size();
        send_cmd(1'b1, 32'h0000_2000, 6'd2);
        bd = rand_beat();
        send_beat(bd);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                #1;
                n++;
            end while (seen.size() < base + 4 && n < 200);
            check("rst_wait_flit3", 72'(seen.size() >= base + 4), 72'(1));
        end
        @(posedge clk);
        #1;
        check("pre_rst_valid", 72'(bus.o_tx_valid), 72'(1));
        check("pre_rst_flit3", bus.o_tx_data, data_flit(0, 3, 2, bd));
        check("pre_rst_tag", 72'(bus.o_tx_data[71:64]), 72'(8'h83));
        rst = 1'b1;
        #1;
        check("async_rst_tx_valid", 72'(bus.o_tx_valid), 72'(0));
        check("async_rst_tx_data", bus.o_tx_data, 72'(0));
        check("async_rst_cmd_ready", 72'(bus.o_cmd_ready), 72'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_cmd_ready", 72'(bus.o_cmd_ready), 72'(1));
        base = seen.size();
        send_cmd(1'b0, 32'h0BAD_F00D, 6'd0);
        wait_idle("post_rst_idle");
        check("post_rst_count", 72'(seen.size() - base), 72'(1));
        check("post_rst_rd_hdr", seen[base], 72'h5A_0000_0000_0BAD_F00D);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
